// File: rtl/pwm_bank_if.sv
// Command port of the PWM bank: one 16-bit command word qualified by a level-held valid,
// plus the error pulse returned for writes to unmapped addresses.
interface pwm_bank_if;
    logic        cmd_valid;
    logic [15:0] cmd_data;
    logic        cmd_err;

    modport master (output cmd_valid, output cmd_data, input cmd_err);
    modport slave  (input cmd_valid, input cmd_data, output cmd_err);
endinterface

// File: rtl/pwm_bank.sv
// Bank of NUM_CH edge-aligned PWM channels sharing one prescaled period counter, with
// double-buffered compares that load at period wrap or on an explicit sync command.
module pwm_bank #(
    parameter int NUM_CH    = 8,
    parameter int CMP_WIDTH = 8,
    parameter int DIV_WIDTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    pwm_bank_if.slave         cmd,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam int PRE_W = (1 << DIV_WIDTH) - 1;
    localparam logic [3:0] NUM_CH_A = 4'(NUM_CH);

    logic                 armed;
    logic                 exec;
    logic [3:0]           addr;
    logic [11:0]          payload;
    logic                 wr_ch;
    logic                 wr_pre;
    logic                 wr_pol;
    logic                 wr_en;
    logic                 sync;
    logic                 bad_addr;
    logic                 unused_bits;

    logic [DIV_WIDTH-1:0] expo;
    logic [PRE_W-1:0]     pre_cnt;
    logic [PRE_W-1:0]     pre_lim;
    logic                 tick;
    logic                 wrap;
    logic [CMP_WIDTH-1:0] cnt;
    logic [NUM_CH-1:0]    pol;
    logic [NUM_CH-1:0]    en;
    logic [NUM_CH-1:0]    pwm_next;
    logic [CMP_WIDTH-1:0] shadow [NUM_CH];
    logic [CMP_WIDTH-1:0] active [NUM_CH];

    // armed means cmd_valid was low last cycle; clearing it in reset makes a
    // valid held across reset release wait for a fresh rising edge.
    assign addr        = cmd.cmd_data[15:12];
    assign payload     = cmd.cmd_data[11:0];
    assign exec        = cmd.cmd_valid & armed;
    assign wr_ch       = exec && (addr < NUM_CH_A);
    assign wr_pre      = exec && (addr == 4'hC);
    assign wr_pol      = exec && (addr == 4'hD);
    assign wr_en       = exec && (addr == 4'hE);
    assign sync        = exec && (addr == 4'hF) && payload[0];
    assign bad_addr    = exec && (addr >= NUM_CH_A) && (addr <= 4'hB);
    assign unused_bits = ^payload;

    always_comb begin
        pre_lim = '0;
        for (int i = 0; i < PRE_W; i++) begin
            pre_lim[i] = (i < int'(expo));
        end
    end

    assign tick = (pre_cnt == pre_lim);
    assign wrap = tick && (&cnt);

    always_comb begin
        pwm_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_next[i] = en[i] ? ((cnt < active[i]) ^ pol[i]) : pol[i];
        end
    end

    // Nonblocking semantics give a wrap-coincident shadow write the old value
    // in the active compare; the new one loads at the next wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed       <= 1'b0;
            cmd.cmd_err <= 1'b0;
            period_tick <= 1'b0;
            expo        <= '0;
            pre_cnt     <= '0;
            cnt         <= '0;
            pol         <= '0;
            en          <= '0;
            pwm_out     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            armed       <= ~cmd.cmd_valid;
            cmd.cmd_err <= bad_addr;
            period_tick <= wrap & ~sync;
            pwm_out     <= pwm_next;

            if (sync) begin
                cnt     <= '0;
                pre_cnt <= '0;
            end else begin
                if (wr_pre || tick) begin
                    pre_cnt <= '0;
                end else begin
                    pre_cnt <= pre_cnt + PRE_W'(1);
                end
                if (tick) begin
                    cnt <= cnt + CMP_WIDTH'(1);
                end
            end

            if (wr_pre) expo <= payload[DIV_WIDTH-1:0];
            if (wr_pol) pol  <= payload[NUM_CH-1:0];
            if (wr_en)  en   <= payload[NUM_CH-1:0];

            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_ch && (addr == 4'(i))) shadow[i] <= payload[CMP_WIDTH-1:0];
                if (sync || wrap)             active[i] <= shadow[i];
            end
        end
    end

endmodule
